// File: rtl/shift_request_pipeline_32.sv
// Request FIFO feeding a 32-bit rotator, with mask/sign-fill to form ROR/ROL/SRL/SLL/SRA,
// and a registered valid/ready result port.
module shift_request_pipeline_32 #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic [4:0]    in_amt,
  input  logic [2:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_err,
  output logic [AW:0]   level
);

  localparam logic [2:0] OpRor = 3'b000;
  localparam logic [2:0] OpRol = 3'b001;
  localparam logic [2:0] OpSrl = 3'b010;
  localparam logic [2:0] OpSll = 3'b011;
  localparam logic [2:0] OpSra = 3'b100;

  localparam logic [AW:0] LevelFull = (AW + 1)'(DEPTH);

  // Entry layout: {op, amt, data}
  logic [39:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          out_valid_q;
  logic [31:0]   out_data_q;
  logic          out_err_q;

  logic push, pop, head_valid;

  // in_ready comes only from the registered level, so a full FIFO never refills same-cycle.
  assign in_ready   = (level_q != LevelFull);
  assign head_valid = (level_q != '0);
  assign push       = in_valid & in_ready;
  assign pop        = head_valid & (~out_valid_q | out_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_op, in_amt, in_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Datapath from the FIFO head
  logic [39:0] head;
  logic [31:0] hd_data;
  logic [4:0]  hd_amt;
  logic [2:0]  hd_op;
  logic        dir;
  logic [5:0]  inv_amt;
  logic [31:0] rot_r, rot_l, rot;
  logic [31:0] mask_r, mask_l;
  logic [31:0] res;
  logic        res_err;

  assign head    = mem_q[rd_ptr_q];
  assign hd_data = head[31:0];
  assign hd_amt  = head[36:32];
  assign hd_op   = head[39:37];

  assign dir     = (hd_op == OpRor) | (hd_op == OpSrl) | (hd_op == OpSra);
  // Shifting by 32 yields zero, which keeps amt=0 rotates exact.
  assign inv_amt = 6'd32 - {1'b0, hd_amt};
  assign rot_r   = (hd_data >> hd_amt) | (hd_data << inv_amt);
  assign rot_l   = (hd_data << hd_amt) | (hd_data >> inv_amt);
  assign rot     = dir ? rot_r : rot_l;
  assign mask_r  = 32'hFFFF_FFFF >> hd_amt;
  assign mask_l  = 32'hFFFF_FFFF << hd_amt;

  always_comb begin
    res     = hd_data;
    res_err = 1'b0;
    case (hd_op)
      OpRor, OpRol: res = rot;
      OpSrl:        res = rot & mask_r;
      OpSll:        res = rot & mask_l;
      OpSra:        res = (rot & mask_r) | (hd_data[31] ? ~mask_r : 32'h0);
      default: begin
        res     = hd_data;
        res_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res;
      out_err_q   <= res_err;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign level     = level_q;

endmodule
